// File: rtl/dft_pkg.sv
// Shared constants and types for the DFT feeder and its sample buffer.
package dft_pkg;

  localparam int unsigned DefWidth     = 12;
  localparam int unsigned DefBinNum    = 4;
  localparam int unsigned DefNMax      = 8192;
  localparam int unsigned DefLogNMax   = $clog2(DefNMax);
  localparam int unsigned DefFifoDepth = 16;

  // Feeder control states: idle, k-marker word, bin words, streaming.
  typedef enum logic [1:0] {
    StIdle,
    StCfgMark,
    StCfgBin,
    StRun
  } feeder_state_e;

  typedef logic signed [DefWidth-1:0] sample_t;

endpackage

// File: rtl/dft_sample_fifo.sv
// Synchronous sample FIFO with registered read data, occupancy output and flush.
// The popped word appears on rdata_o the cycle after pop_i and holds until the next pop.
module dft_sample_fifo #(
  parameter int unsigned Width = 12,
  parameter int unsigned Depth = 16
) (
  input  logic                     clk_i,
  input  logic                     rst_ni,
  input  logic                     flush_i,
  input  logic                     push_i,
  input  logic [Width-1:0]         wdata_i,
  input  logic                     pop_i,
  output logic [Width-1:0]         rdata_o,
  output logic [$clog2(Depth):0]   level_o,
  output logic                     full_o,
  output logic                     empty_o
);

  localparam int unsigned PtrW = $clog2(Depth);
  localparam int unsigned LvlW = PtrW + 1;

  logic [Width-1:0] mem_q [Depth];
  logic [PtrW-1:0]  wptr_q, wptr_d;
  logic [PtrW-1:0]  rptr_q, rptr_d;
  logic [LvlW-1:0]  level_q, level_d;
  logic [Width-1:0] rdata_q, rdata_d;
  logic             push_ok, pop_ok;

  assign full_o  = (level_q == LvlW'(Depth));
  assign empty_o = (level_q == '0);

  // Flush overrides any push or pop in the same cycle.
  assign push_ok = push_i && !full_o && !flush_i;
  assign pop_ok  = pop_i && !empty_o && !flush_i;

  // Next-state for pointers, occupancy and the read register.
  always_comb begin
    wptr_d  = wptr_q;
    rptr_d  = rptr_q;
    level_d = level_q;
    rdata_d = rdata_q;
    if (flush_i) begin
      wptr_d  = '0;
      rptr_d  = '0;
      level_d = '0;
    end else begin
      wptr_d  = wptr_q + PtrW'(push_ok);
      rptr_d  = rptr_q + PtrW'(pop_ok);
      level_d = level_q + LvlW'(push_ok) - LvlW'(pop_ok);
      if (pop_ok) begin
        rdata_d = mem_q[rptr_q];
      end
    end
  end

  // Control state registers.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      level_q <= '0;
      rdata_q <= '0;
    end else begin
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      level_q <= level_d;
      rdata_q <= rdata_d;
    end
  end

  // Storage array; contents are don't-care until written.
  always_ff @(posedge clk_i) begin
    if (push_ok) begin
      mem_q[wptr_q] <= wdata_i;
    end
  end

  assign rdata_o = rdata_q;
  assign level_o = level_q;

endmodule

// File: rtl/dft_feeder.sv
// Upstream stage of DFT_q: programs the bin table via the k-marker sequence, buffers
// samples and issues one write strobe per completed sweep.
module dft_feeder
  import dft_pkg::*;
#(
  parameter int unsigned WIDTH      = DefWidth,
  parameter int unsigned BIN_NUM    = DefBinNum,
  parameter int unsigned N_MAX      = DefNMax,
  parameter int unsigned LOG_N_MAX  = $clog2(N_MAX),
  parameter int unsigned FIFO_DEPTH = DefFifoDepth
) (
  input  logic                                 i_sys_clk,
  input  logic                                 i_sys_rst_n,
  input  logic                                 i_cfg_start,
  input  logic [BIN_NUM-1:0][LOG_N_MAX-1:0]    i_k_table,
  input  logic [$clog2(LOG_N_MAX)-1:0]         i_N_cfg,
  input  logic signed [WIDTH-1:0]              i_s_data,
  input  logic                                 i_s_valid,
  output logic                                 o_s_ready,
  output logic signed [WIDTH-1:0]              o_x,
  output logic                                 o_wr,
  output logic [LOG_N_MAX:0]                   o_k,
  output logic [$clog2(LOG_N_MAX)-1:0]         o_N,
  input  logic                                 i_done,
  output logic                                 o_busy,
  output logic [$clog2(FIFO_DEPTH):0]          o_level,
  output logic                                 o_overflow
);

  localparam int unsigned NW   = $clog2(LOG_N_MAX);
  localparam int unsigned CntW = (BIN_NUM > 1) ? $clog2(BIN_NUM) : 1;
  localparam logic [CntW-1:0]    CntLast = CntW'(BIN_NUM - 1);
  localparam logic [LOG_N_MAX:0] KMark   = N_MAX[LOG_N_MAX:0];

  feeder_state_e state_q, state_d;
  logic [CntW-1:0]                      cnt_q, cnt_d;
  logic [BIN_NUM-1:0][LOG_N_MAX-1:0]    k_table_q, k_table_d;
  logic [NW-1:0]                        n_q, n_d;
  logic [LOG_N_MAX:0]                   k_q, k_d;
  logic                                 wr_q, wr_d;
  logic                                 wr_dly_q, wr_dly_d;
  logic                                 dft_ready_q, dft_ready_d;
  logic                                 overflow_q, overflow_d;

  logic                                 s_ready;
  logic                                 done_ok;
  logic                                 fifo_flush, fifo_push, fifo_pop;
  logic                                 fifo_full, fifo_empty;
  logic [WIDTH-1:0]                     fifo_rdata;
  logic [$clog2(FIFO_DEPTH):0]          fifo_level;

  dft_sample_fifo #(
    .Width (WIDTH),
    .Depth (FIFO_DEPTH)
  ) u_fifo (
    .clk_i   (i_sys_clk),
    .rst_ni  (i_sys_rst_n),
    .flush_i (fifo_flush),
    .push_i  (fifo_push),
    .wdata_i (i_s_data),
    .pop_i   (fifo_pop),
    .rdata_o (fifo_rdata),
    .level_o (fifo_level),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );

  // Readiness depends only on full so a same-cycle pop never opens a slot early.
  assign s_ready = (state_q == StRun) && !fifo_full;

  // o_done is ignored while o_wr is high and one cycle after, masking a stale level.
  assign done_ok = (state_q == StRun) && i_done && !wr_q && !wr_dly_q;

  // Next-state: configuration sequencing, push/pop control and sweep handshake.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    k_table_d   = k_table_q;
    n_d         = n_q;
    k_d         = k_q;
    wr_d        = 1'b0;
    wr_dly_d    = wr_q;
    dft_ready_d = dft_ready_q;
    overflow_d  = overflow_q;
    fifo_flush  = 1'b0;
    fifo_push   = 1'b0;
    fifo_pop    = 1'b0;

    if (i_cfg_start) begin
      // A new configuration wins over any traffic in the same cycle.
      k_table_d   = i_k_table;
      n_d         = i_N_cfg;
      fifo_flush  = 1'b1;
      overflow_d  = 1'b0;
      dft_ready_d = 1'b0;
      k_d         = KMark;
      state_d     = StCfgMark;
    end else begin
      unique case (state_q)
        StIdle: begin
        end
        StCfgMark: begin
          cnt_d   = '0;
          k_d     = {1'b0, k_table_q[0]};
          state_d = StCfgBin;
        end
        StCfgBin: begin
          if (cnt_q == CntLast) begin
            state_d     = StRun;
            dft_ready_d = 1'b1;
          end else begin
            cnt_d = cnt_q + 1'b1;
            k_d   = {1'b0, k_table_q[cnt_d]};
          end
        end
        StRun: begin
          fifo_push = i_s_valid && s_ready;
          if (i_s_valid && !s_ready) begin
            overflow_d = 1'b1;
          end
          if (!fifo_empty && (dft_ready_q || done_ok)) begin
            fifo_pop    = 1'b1;
            wr_d        = 1'b1;
            dft_ready_d = 1'b0;
          end else if (done_ok) begin
            dft_ready_d = 1'b1;
          end
        end
        default: state_d = StIdle;
      endcase
    end
  end

  // State registers.
  always_ff @(posedge i_sys_clk or negedge i_sys_rst_n) begin
    if (!i_sys_rst_n) begin
      state_q     <= StIdle;
      cnt_q       <= '0;
      k_table_q   <= '0;
      n_q         <= '0;
      k_q         <= '0;
      wr_q        <= 1'b0;
      wr_dly_q    <= 1'b0;
      dft_ready_q <= 1'b0;
      overflow_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      k_table_q   <= k_table_d;
      n_q         <= n_d;
      k_q         <= k_d;
      wr_q        <= wr_d;
      wr_dly_q    <= wr_dly_d;
      dft_ready_q <= dft_ready_d;
      overflow_q  <= overflow_d;
    end
  end

  assign o_s_ready  = s_ready;
  assign o_x        = fifo_rdata;
  assign o_wr       = wr_q;
  assign o_k        = k_q;
  assign o_N        = n_q;
  assign o_level    = fifo_level;
  assign o_overflow = overflow_q;
  assign o_busy     = (fifo_level != '0) || ((state_q == StRun) && !dft_ready_q);

endmodule
